id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- Decode-to-execute pipeline register that feeds the 16-bit ALU.
- Latches decoded instruction fields and register operands.
- Resolves RAW hazards by forwarding from the EX/MEM and MEM/WB registers.
- Inserts bubbles for load-use hazards. Supports a downstream stall (valid/ready) and a branch/jump flush.

Parameters:
- DW, 16, operand/data width
- RW, 3, register index width (8 GPRs, no hard-wired zero register)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-low
- flush  in  1  squash the held instruction and the incoming instruction
- in_valid  in  1  decode presents an instruction
- in_ready  out  1  stage accepts the instruction this cycle
- in_opcode  in  5  instruction opcode
- in_funct  in  2  R-format function field
- in_rs_idx, in_rt_idx, in_rd_idx  in  RW each  source/destination indices
- in_rs_used, in_rt_used  in  1 each  source actually read
- in_rs_data, in_rt_data  in  DW each  register file read data
- in_imm  in  DW  sign/zero-extended immediate
- in_use_imm  in  1  Bin takes the immediate
- in_reg_write  in  1  instruction writes rd
- in_mem_read  in  1  instruction is a load
- fwd_ex_wr, fwd_ex_idx, fwd_ex_data  in  1/RW/DW  EX/MEM result; upstream drives wr=0 for loads
- fwd_wb_wr, fwd_wb_idx, fwd_wb_data  in  1/RW/DW  MEM/WB writeback value
- out_valid  out  1  held instruction valid
- out_ready  in  1  execute consumes the held instruction (0 freezes back end)
- alu_opcode  out  5  opcode to ALU
- alu_funct  out  2  funct to ALU
- alu_ain, alu_bin  out  DW each  ALU operands
- out_st_data  out  DW  forwarded rt value (store data)
- out_rd_idx  out  RW  destination index
- out_reg_write, out_mem_read  out  1 each  control passthrough

Behaviour:
- Reset (rst=0, async): every output register = 0, out_valid=0, load-pending tracker cleared.
- Operand select at capture, per source:
  - fwd_ex_data if fwd_ex_wr and fwd_ex_idx matches.
  - Else fwd_wb_data if fwd_wb_wr and fwd_wb_idx matches.
  - Else in_*_data.
  - EX has priority over WB.
  - An unused source (in_*_used=0) still goes through selection; its value is don't-care.
- alu_ain = selected rs. alu_bin = in_use_imm ? in_imm : selected rt. out_st_data = selected rt.
- Latency: 1 cycle from acceptance to the out_* presentation.
- Hazard, combinational: in_valid and a used source index equals the tracked load rd, in either of two cases:
  - (a) out_valid, out_mem_read and out_reg_write hold (load in this stage); compare with out_rd_idx.
  - (b) ld_pend is set; compare with ld_pend_idx.
- in_ready = (!out_valid || out_ready) && !hazard && !flush.
- ld_pend tracker:
  - Set, with ld_pend_idx = out_rd_idx, when a load with reg_write is consumed (out_valid && out_ready).
  - Otherwise cleared when out_ready=1.
  - Held while out_ready=0.
  - Result: exactly two bubbles between a load and a dependent instruction; the dependent captures its data from MEM/WB.
- Next state:
  - flush: out_valid<=0, ld_pend<=0, incoming dropped.
  - Else accept (in_valid && in_ready): load all out_* registers, out_valid<=1.
  - Else if out_ready: out_valid<=0 (bubble; data fields may hold stale values).
  - Else: hold all registers.
- flush dominates both accept and out_ready in the same cycle.
- While out_valid=1 and out_ready=0, all outputs are stable.

Test Plan:
- Basic ADD:
  - Stimulus: opcode 11011, funct 00, rs=1 (0x0003), rt=2 (0x0004), no forwarding matches.
  - Response: next cycle out_valid=1, alu_ain=0x0003, alu_bin=0x0004, alu_funct=00.
- Forwarding priority:
  - Stimulus: rs=5; fwd_ex (5, 0x1111) and fwd_wb (5, 0x2222) both asserted.
  - Response: alu_ain=0x1111. With fwd_ex_wr=0 -> 0x2222.
- Immediate:
  - Stimulus: ADDI, in_use_imm=1, imm=0xFFFE, rt=3 matched by fwd_wb (0x00AA).
  - Response: alu_bin=0xFFFE, out_st_data=0x00AA.
- Load-use:
  - Stimulus: LD r4 accepted, then ADD r1=r4+r2 on in_valid, out_ready=1.
  - Response: in_ready=0 for 2 cycles; out_valid pattern 1,0,0,1; ADD captures fwd_wb_data (0xBEEF), so alu_ain=0xBEEF.
- Back-pressure and flush:
  - Stimulus: out_ready=0 for 3 cycles.
  - Response: outputs constant, in_ready=0. Then flush=1 with in_valid=1 -> next cycle out_valid=0, ld_pend=0, nothing accepted.
- Reset mid-operation:
  - Stimulus: assert rst=0 asynchronously while out_valid=1 and ld_pend=1.
  - Response: outputs and tracker zero immediately, without a clock edge. After rst=1, the first accepted instruction behaves as in the basic ADD case.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the 16-bit ALU: operand forwarding from EX/MEM and MEM/WB,
// load-use bubble insertion, valid/ready back-pressure and branch/jump flush.
module id_ex_stage #(
   parameter int DW = 16,
   parameter int RW = 3
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [4:0]    in_opcode,
   input  logic [1:0]    in_funct,
   input  logic [RW-1:0] in_rs_idx,
   input  logic [RW-1:0] in_rt_idx,
   input  logic [RW-1:0] in_rd_idx,
   input  logic          in_rs_used,
   input  logic          in_rt_used,
   input  logic [DW-1:0] in_rs_data,
   input  logic [DW-1:0] in_rt_data,
   input  logic [DW-1:0] in_imm,
   input  logic          in_use_imm,
   input  logic          in_reg_write,
   input  logic          in_mem_read,
   input  logic          fwd_ex_wr,
   input  logic [RW-1:0] fwd_ex_idx,
   input  logic [DW-1:0] fwd_ex_data,
   input  logic          fwd_wb_wr,
   input  logic [RW-1:0] fwd_wb_idx,
   input  logic [DW-1:0] fwd_wb_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [4:0]    alu_opcode,
   output logic [1:0]    alu_funct,
   output logic [DW-1:0] alu_ain,
   output logic [DW-1:0] alu_bin,
   output logic [DW-1:0] out_st_data,
   output logic [RW-1:0] out_rd_idx,
   output logic          out_reg_write,
   output logic          out_mem_read
);

   logic          ld_pend;
   logic [RW-1:0] ld_pend_idx;
   logic [DW-1:0] rs_sel;
   logic [DW-1:0] rt_sel;
   logic          ld_in_stage;
   logic          hit_stage;
   logic          hit_pend;
   logic          hazard;
   logic          accept;
   logic          consume_load;

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      rs_sel = in_rs_data;
      if (fwd_ex_wr && (fwd_ex_idx == in_rs_idx))
         rs_sel = fwd_ex_data;
      else if (fwd_wb_wr && (fwd_wb_idx == in_rs_idx))
         rs_sel = fwd_wb_data;
   end

   always_comb begin
      rt_sel = in_rt_data;
      if (fwd_ex_wr && (fwd_ex_idx == in_rt_idx))
         rt_sel = fwd_ex_data;
      else if (fwd_wb_wr && (fwd_wb_idx == in_rt_idx))
         rt_sel = fwd_wb_data;
   end

   // A load's data only reaches MEM/WB two cycles later, so it stalls while in this stage or pending.
   assign ld_in_stage = out_valid && out_mem_read && out_reg_write;
   assign hit_stage   = ld_in_stage &&
                        ((in_rs_used && (in_rs_idx == out_rd_idx)) ||
                         (in_rt_used && (in_rt_idx == out_rd_idx)));
   assign hit_pend    = ld_pend &&
                        ((in_rs_used && (in_rs_idx == ld_pend_idx)) ||
                         (in_rt_used && (in_rt_idx == ld_pend_idx)));
   assign hazard       = in_valid && (hit_stage || hit_pend);
   assign in_ready     = (!out_valid || out_ready) && !hazard && !flush;
   assign accept       = in_valid && in_ready;
   assign consume_load = ld_in_stage && out_ready;

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_valid     <= 1'b0;
         alu_opcode    <= '0;
         alu_funct     <= '0;
         alu_ain       <= '0;
         alu_bin       <= '0;
         out_st_data   <= '0;
         out_rd_idx    <= '0;
         out_reg_write <= 1'b0;
         out_mem_read  <= 1'b0;
         ld_pend       <= 1'b0;
         ld_pend_idx   <= '0;
      end else if (flush) begin
         out_valid <= 1'b0;
         ld_pend   <= 1'b0;
      end else begin
         if (consume_load) begin
            ld_pend     <= 1'b1;
            ld_pend_idx <= out_rd_idx;
         end else if (out_ready) begin
            ld_pend <= 1'b0;
         end

         if (accept) begin
            out_valid     <= 1'b1;
            alu_opcode    <= in_opcode;
            alu_funct     <= in_funct;
            alu_ain       <= rs_sel;
            alu_bin       <= in_use_imm ? in_imm : rt_sel;
            out_st_data   <= rt_sel;
            out_rd_idx    <= in_rd_idx;
            out_reg_write <= in_reg_write;
            out_mem_read  <= in_mem_read;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: table of single-instruction captures plus
// hand-written load-use, back-pressure/flush and asynchronous reset sequences.
module tb_id_ex_stage;

   localparam int DW = 16;
   localparam int RW = 3;

   logic          clk = 1'b0;
   logic          rst;
   logic          flush;
   logic          in_valid;
   logic          in_ready;
   logic [4:0]    in_opcode;
   logic [1:0]    in_funct;
   logic [RW-1:0] in_rs_idx, in_rt_idx, in_rd_idx;
   logic          in_rs_used, in_rt_used;
   logic [DW-1:0] in_rs_data, in_rt_data, in_imm;
   logic          in_use_imm, in_reg_write, in_mem_read;
   logic          fwd_ex_wr, fwd_wb_wr;
   logic [RW-1:0] fwd_ex_idx, fwd_wb_idx;
   logic [DW-1:0] fwd_ex_data, fwd_wb_data;
   logic          out_valid;
   logic          out_ready;
   logic [4:0]    alu_opcode;
   logic [1:0]    alu_funct;
   logic [DW-1:0] alu_ain, alu_bin, out_st_data;
   logic [RW-1:0] out_rd_idx;
   logic          out_reg_write, out_mem_read;

   int checks = 0;
   int errors = 0;

   id_ex_stage #(.DW(DW), .RW(RW)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_opcode(in_opcode), .in_funct(in_funct),
      .in_rs_idx(in_rs_idx), .in_rt_idx(in_rt_idx), .in_rd_idx(in_rd_idx),
      .in_rs_used(in_rs_used), .in_rt_used(in_rt_used),
      .in_rs_data(in_rs_data), .in_rt_data(in_rt_data),
      .in_imm(in_imm), .in_use_imm(in_use_imm),
      .in_reg_write(in_reg_write), .in_mem_read(in_mem_read),
      .fwd_ex_wr(fwd_ex_wr), .fwd_ex_idx(fwd_ex_idx), .fwd_ex_data(fwd_ex_data),
      .fwd_wb_wr(fwd_wb_wr), .fwd_wb_idx(fwd_wb_idx), .fwd_wb_data(fwd_wb_data),
      .out_valid(out_valid), .out_ready(out_ready),
      .alu_opcode(alu_opcode), .alu_funct(alu_funct),
      .alu_ain(alu_ain), .alu_bin(alu_bin), .out_st_data(out_st_data),
      .out_rd_idx(out_rd_idx), .out_reg_write(out_reg_write), .out_mem_read(out_mem_read)
   );

   always #5 clk = ~clk;

   typedef struct {
      string         name;
      logic [4:0]    opcode;
      logic [1:0]    funct;
      logic [RW-1:0] rs, rt, rd;
      logic [DW-1:0] rs_data, rt_data, imm;
      logic          use_imm;
      logic          ex_wr;
      logic [RW-1:0] ex_idx;
      logic [DW-1:0] ex_data;
      logic          wb_wr;
      logic [RW-1:0] wb_idx;
      logic [DW-1:0] wb_data;
      logic [DW-1:0] exp_ain, exp_bin, exp_st;
   } vec_t;

   vec_t vecs[6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic clear_fwd();
      fwd_ex_wr = 1'b0; fwd_ex_idx = '0; fwd_ex_data = '0;
      fwd_wb_wr = 1'b0; fwd_wb_idx = '0; fwd_wb_data = '0;
   endtask

   task automatic drive(input logic [4:0] op, input logic [RW-1:0] rs, input logic [RW-1:0] rt,
                        input logic [RW-1:0] rd, input logic rs_used, input logic rt_used,
                        input logic [DW-1:0] rs_data, input logic [DW-1:0] rt_data,
                        input logic [DW-1:0] imm, input logic use_imm, input logic mem_read);
      in_valid = 1'b1; in_opcode = op; in_funct = 2'b00;
      in_rs_idx = rs; in_rt_idx = rt; in_rd_idx = rd;
      in_rs_used = rs_used; in_rt_used = rt_used;
      in_rs_data = rs_data; in_rt_data = rt_data;
      in_imm = imm; in_use_imm = use_imm;
      in_reg_write = 1'b1; in_mem_read = mem_read;
   endtask

   task automatic run_vec(input vec_t v);
      @(negedge clk);
      drive(v.opcode, v.rs, v.rt, v.rd, 1'b1, 1'b1, v.rs_data, v.rt_data, v.imm, v.use_imm, 1'b0);
      in_funct = v.funct;
      fwd_ex_wr = v.ex_wr; fwd_ex_idx = v.ex_idx; fwd_ex_data = v.ex_data;
      fwd_wb_wr = v.wb_wr; fwd_wb_idx = v.wb_idx; fwd_wb_data = v.wb_data;
      #1 check({v.name, " in_ready"}, 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      check({v.name, " out_valid"}, 32'(out_valid), 32'd1);
      check({v.name, " alu_ain"}, 32'(alu_ain), 32'(v.exp_ain));
      check({v.name, " alu_bin"}, 32'(alu_bin), 32'(v.exp_bin));
      check({v.name, " out_st_data"}, 32'(out_st_data), 32'(v.exp_st));
      check({v.name, " alu_opcode"}, 32'(alu_opcode), 32'(v.opcode));
      check({v.name, " alu_funct"}, 32'(alu_funct), 32'(v.funct));
      check({v.name, " out_rd_idx"}, 32'(out_rd_idx), 32'(v.rd));
   endtask

   initial begin
      //           name        op        fn     rs rt rd rs_data  rt_data  imm      ui  exwr exi exdata   wbwr wbi wbdata   ain      bin      st
      vecs[0] = '{"add",     5'b11011, 2'b00, 1, 2, 3, 16'h0003, 16'h0004, 16'h0000, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0003, 16'h0004, 16'h0004};
      vecs[1] = '{"fwd_prio", 5'b11011, 2'b01, 5, 6, 2, 16'h0555, 16'h0066, 16'h0000, 0, 1, 5, 16'h1111, 1, 5, 16'h2222, 16'h1111, 16'h0066, 16'h0066};
      vecs[2] = '{"fwd_wb",  5'b11011, 2'b10, 5, 6, 2, 16'h0555, 16'h0066, 16'h0000, 0, 0, 5, 16'h1111, 1, 5, 16'h2222, 16'h2222, 16'h0066, 16'h0066};
      vecs[3] = '{"addi",    5'b01000, 2'b00, 0, 3, 3, 16'h0100, 16'h0033, 16'hFFFE, 1, 0, 0, 16'h0000, 1, 3, 16'h00AA, 16'h0100, 16'hFFFE, 16'h00AA};
      vecs[4] = '{"split",   5'b11011, 2'b11, 7, 2, 1, 16'h0007, 16'h0002, 16'h0000, 0, 1, 2, 16'hE2E2, 1, 7, 16'h7777, 16'h7777, 16'hE2E2, 16'hE2E2};
      vecs[5] = '{"nomatch", 5'b11011, 2'b00, 1, 4, 5, 16'h0101, 16'h0404, 16'h0000, 0, 1, 6, 16'hDEAD, 1, 2, 16'hBEEF, 16'h0101, 16'h0404, 16'h0404};

      rst = 1'b0; flush = 1'b0; out_ready = 1'b1;
      in_valid = 1'b0;
      drive(5'b0, 0, 0, 0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
      in_valid = 1'b0;
      clear_fwd();
      #2;
      check("reset out_valid", 32'(out_valid), 32'd0);
      check("reset alu_ain", 32'(alu_ain), 32'd0);
      check("reset out_reg_write", 32'(out_reg_write), 32'd0);
      @(negedge clk); rst = 1'b1;

      for (int i = 0; i < 6; i++) run_vec(vecs[i]);
      @(negedge clk); in_valid = 1'b0; clear_fwd();
      @(posedge clk); #1 check("idle bubble out_valid", 32'(out_valid), 32'd0);

      // Load-use: LD r4, then ADD r1 = r4 + r2 needs two bubbles and takes r4 from MEM/WB.
      @(negedge clk);
      drive(5'b10000, 1, 0, 4, 1'b1, 1'b0, 16'h0010, 16'h0, 16'h0002, 1'b1, 1'b1);
      #1 check("ld in_ready", 32'(in_ready), 32'd1);
      @(posedge clk); #1 check("ld out_valid", 32'(out_valid), 32'd1);
      check("ld out_mem_read", 32'(out_mem_read), 32'd1);
      @(negedge clk);
      drive(5'b11011, 4, 2, 1, 1'b1, 1'b1, 16'h0000, 16'h0005, 16'h0, 1'b0, 1'b0);
      #1 check("lu stall1 in_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1 check("lu bubble1 out_valid", 32'(out_valid), 32'd0);
      @(negedge clk);
      #1 check("lu stall2 in_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1 check("lu bubble2 out_valid", 32'(out_valid), 32'd0);
      @(negedge clk);
      fwd_wb_wr = 1'b1; fwd_wb_idx = 4; fwd_wb_data = 16'hBEEF;
      #1 check("lu go in_ready", 32'(in_ready), 32'd1);
      @(posedge clk); #1 check("lu add out_valid", 32'(out_valid), 32'd1);
      check("lu add alu_ain", 32'(alu_ain), 32'hBEEF);
      check("lu add alu_bin", 32'(alu_bin), 32'h0005);
      @(negedge clk); in_valid = 1'b0; clear_fwd();
      @(posedge clk);

      // Back-pressure: LD r6 held for 3 cycles, then flushed together with its dependent.
      @(negedge clk);
      out_ready = 1'b0;
      drive(5'b10000, 1, 0, 6, 1'b1, 1'b0, 16'h0020, 16'h0000, 16'h0010, 1'b1, 1'b1);
      @(posedge clk); #1 check("bp capture out_valid", 32'(out_valid), 32'd1);
      @(negedge clk);
      drive(5'b11011, 2, 3, 7, 1'b1, 1'b1, 16'h1234, 16'h5678, 16'h0, 1'b0, 1'b0);
      for (int c = 0; c < 3; c++) begin
         #1 check("bp in_ready", 32'(in_ready), 32'd0);
         @(posedge clk); #1;
         check("bp out_valid", 32'(out_valid), 32'd1);
         check("bp alu_ain", 32'(alu_ain), 32'h0020);
         check("bp alu_bin", 32'(alu_bin), 32'h0010);
         check("bp out_rd_idx", 32'(out_rd_idx), 32'd6);
         @(negedge clk);
      end
      flush = 1'b1; out_ready = 1'b1;
      drive(5'b11011, 6, 2, 7, 1'b1, 1'b1, 16'h0606, 16'h0202, 16'h0, 1'b0, 1'b0);
      #1 check("flush in_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1 check("flush out_valid", 32'(out_valid), 32'd0);
      @(negedge clk); flush = 1'b0;
      #1 check("post-flush no ld_pend in_ready", 32'(in_ready), 32'd1);
      @(posedge clk); #1 check("post-flush out_valid", 32'(out_valid), 32'd1);
      check("post-flush alu_ain", 32'(alu_ain), 32'h0606);

      // Reset mid-operation with LD r5 in stage and LD r4 pending.
      @(negedge clk);
      drive(5'b10000, 1, 0, 4, 1'b1, 1'b0, 16'h0001, 16'h0, 16'h0004, 1'b1, 1'b1);
      @(negedge clk);
      drive(5'b10000, 1, 0, 5, 1'b1, 1'b0, 16'h0001, 16'h0, 16'h0008, 1'b1, 1'b1);
      #1 check("rst pre in_ready", 32'(in_ready), 32'd1);
      @(posedge clk); #1 check("rst pre out_valid", 32'(out_valid), 32'd1);
      in_valid = 1'b0;
      #2 rst = 1'b0;
      #1;
      check("async rst out_valid", 32'(out_valid), 32'd0);
      check("async rst alu_bin", 32'(alu_bin), 32'd0);
      check("async rst out_mem_read", 32'(out_mem_read), 32'd0);
      check("async rst out_rd_idx", 32'(out_rd_idx), 32'd0);
      @(negedge clk); rst = 1'b1;
      drive(5'b11011, 4, 5, 3, 1'b1, 1'b1, 16'h0003, 16'h0004, 16'h0, 1'b0, 1'b0);
      #1 check("post-rst in_ready", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      check("post-rst out_valid", 32'(out_valid), 32'd1);
      check("post-rst alu_ain", 32'(alu_ain), 32'h0003);
      check("post-rst alu_bin", 32'(alu_bin), 32'h0004);
      @(negedge clk); in_valid = 1'b0;
      @(posedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
